// File: rtl/steering_feedback_rx.sv
// Steering-angle feedback receiver: 2-flop sync, start/9-data/parity/stop
// frame decode, range check and link-health timer.
module steering_feedback_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       rxLine,
  output logic [8:0] currentDirection,
  output logic       directionValid,
  output logic       parityError,
  output logic       frameError,
  output logic       rangeError,
  output logic       linkUp
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CLKS - 1);
  localparam logic [8:0] MAX_DEG = 9'd359;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t state, state_n;

  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    idx, idx_n;
  logic [8:0]    shreg, shreg_n;
  logic          par, par_n;
  logic          tick;
  logic          set_valid;
  logic          set_par;
  logic          set_frame;
  logic          set_range;
  logic [31:0]   tmr;

  assign tick = (cnt == '0);

  // Synchronizer idles high so reset never looks like a start edge
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxLine;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      par   <= par_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = tick ? cnt : cnt - 1'b1;
    idx_n     = idx;
    shreg_n   = shreg;
    par_n     = par;
    set_valid = 1'b0;
    set_par   = 1'b0;
    set_frame = 1'b0;
    set_range = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = HALF;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            cnt_n   = FULL;
            idx_n   = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = {rx_s, shreg[8:1]};
          cnt_n   = FULL;
          idx_n   = idx + 4'd1;
          if (idx == 4'd8) state_n = PARITY;
        end
      end
      PARITY: begin
        if (tick) begin
          par_n   = rx_s;
          cnt_n   = FULL;
          state_n = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          if (!rx_s) begin
            set_frame = 1'b1;
            state_n   = BREAK;
          end else if ((^shreg) != par) begin
            set_par = 1'b1;
          end else if (shreg > MAX_DEG) begin
            set_range = 1'b1;
          end else begin
            set_valid = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      currentDirection <= '0;
      directionValid   <= 1'b0;
      parityError      <= 1'b0;
      frameError       <= 1'b0;
      rangeError       <= 1'b0;
    end else begin
      directionValid <= set_valid;
      parityError    <= set_par;
      frameError     <= set_frame;
      rangeError     <= set_range;
      if (set_valid) currentDirection <= shreg;
    end
  end

  // A fresh valid frame takes priority over a coincident expiry
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      tmr    <= '0;
      linkUp <= 1'b0;
    end else if (set_valid) begin
      tmr    <= '0;
      linkUp <= 1'b1;
    end else begin
      if (tmr != '1) tmr <= tmr + 32'd1;
      if (tmr == TMO_LAST) linkUp <= 1'b0;
    end
  end

endmodule

// File: doc/steering_feedback_rx.md
# steering_feedback_rx

Serial receiver for the steering-angle feedback frame that the steering Arduino returns on a single GPIO line; it is the inbound counterpart of the outbound steering command link. It oversamples the line on CLOCK_50, decodes a start/9-data/parity/stop frame, range-checks the angle and presents the last good heading, with error and link-health flags, to the processor side of the custom logic.

## Interface
- CLKS_PER_BIT, 434: CLOCK_50 cycles per bit (115200 baud); must be ≥ 4.
- TIMEOUT_CLKS, 5000000: cycles without a valid frame before the link is declared lost (100 ms).
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (KEY[0]).
- rxLine  in  1  serial input from the Arduino. Asynchronous; idle high.
- currentDirection  out  9  last valid angle in degrees, 0–359.
- directionValid  out  1  one-cycle pulse when currentDirection updates.
- parityError  out  1  one-cycle pulse: parity mismatch, frame discarded.
- frameError  out  1  one-cycle pulse: stop bit sampled low, frame discarded.
- rangeError  out  1  one-cycle pulse: payload > 359, frame discarded.
- linkUp  out  1  high while valid frames arrive within TIMEOUT_CLKS.

## Operation
- Frame, LSB first: start (0), d0..d8, even parity (XOR of d0..d8 equals the parity bit), stop (1).
- rxLine passes through a 2-flop synchronizer. All logic uses the synchronized value rxS.
- FSM states:
  - IDLE: on rxS = 0, go to START and load the bit counter with CLKS_PER_BIT/2 − 1.
  - START: at counter expiry, sample. If rxS = 1, the event was a glitch; return to IDLE with no flag. If rxS = 0, go to DATA, reload CLKS_PER_BIT − 1, and clear the bit index.
  - DATA: at each expiry, shift rxS into bit[index]. After index 8, go to PARITY.
  - PARITY: sample the parity bit and go to STOP.
  - STOP: sample the stop bit. Frames are then checked in priority order:
    - stop = 0: pulse frameError and go to BREAK.
    - parity mismatch: pulse parityError and go to IDLE.
    - payload > 359: pulse rangeError and go to IDLE.
    - otherwise: load currentDirection, pulse directionValid, and go to IDLE.
  - BREAK: wait for rxS = 1, then go to IDLE. This prevents a held-low line from retriggering a start.
- Exactly one of the four result pulses fires per completed frame. Glitch rejects fire none.
- Link timer:
  - It is a saturating 32-bit counter, cleared on every directionValid.
  - linkUp is set by directionValid.
  - linkUp is cleared when the counter reaches TIMEOUT_CLKS − 1 with no directionValid.
  - Error frames do not reset the timer.
- No processor-side handshake. The consumer samples currentDirection on directionValid or at any time; the value is stable between pulses.

## Timing
- Reset (reset = 0, asynchronous) forces every output to 0:
  - currentDirection = 0, all pulses = 0, linkUp = 0.
  - FSM returns to IDLE and counters clear.
  - Synchronizer flops reset to 1 (idle).
- Reset mid-frame abandons the frame. After release, the receiver rearms only on a fresh falling edge.
- Input latency: 2 cycles through the synchronizer.
- Samples are taken at bit centres:
  - Start-bit sample: CLKS_PER_BIT/2 cycles after the falling edge of rxS.
  - Each later sample: CLKS_PER_BIT cycles after the previous one.
- Result pulses assert on the cycle after the stop sample and last exactly 1 cycle.
- currentDirection changes on the same edge that raises directionValid.
- Back-to-back frames with zero idle bits are supported: IDLE detects the next start edge in the cycle after STOP.
- Simultaneous timeout expiry and directionValid: directionValid wins, so linkUp stays 1.
- Counter widths: the bit counter is clog2(CLKS_PER_BIT) bits; the index is 4 bits. Range compare is an unsigned 9-bit compare against 359.

## Test plan
- Bench uses CLKS_PER_BIT = 8, TIMEOUT_CLKS = 2000.
- Reset/idle:
  - Hold reset low, then release with rxLine = 1 for 500 cycles.
  - Required: all outputs 0 and no pulses.
- Valid frame:
  - Send 270 (0b100001110, parity 0).
  - Required: directionValid pulses once, currentDirection = 270, linkUp = 1.
  - Send 90 back-to-back; required: currentDirection = 90 with a second pulse, no errors.
- Parity error:
  - Send 90 with parity bit 1.
  - Required: parityError pulses once; currentDirection stays at its previous value.
- Range and framing errors:
  - Send 400 (0b110010000, parity 1). Required: rangeError pulses once and currentDirection is unchanged.
  - Send 45 with stop = 0, then hold the line low for 50 cycles. Required: frameError pulses once with no further activity until the line returns high.
  - Then send 45 correctly. Required: directionValid pulses and currentDirection = 45.
- Glitch, timeout and mid-frame reset:
  - Drive a 2-cycle low pulse on rxLine. Required: no output activity.
  - Stop traffic for 2000 cycles after a valid frame. Required: linkUp falls at cycle 2000.
  - Assert reset during bit d4. Required: all outputs return to 0 immediately, and the next full frame of 123 is received correctly.
